// File: rtl/cluster_pwr_seq.sv
// Cluster power/boot sequencer: turns SoC control bits into an ordered switch/iso/clock/reset sequence.
// Latency: every output is a flop updated with the state register; the ack path adds a 2-flop synchronizer.
// Backpressure: none; each step waits on the synchronized switch ack or a fixed settling count.
//
// Ports:
//   HCLK, HRESET            clock, asynchronous active-high reset
//   cluster_pow_i           power request from SoC control
//   cluster_byp_i           bypass, 1 forces the cluster down
//   cluster_rstn_i          software cluster reset (active-low), honoured only in RUN
//   cluster_fetch_enable_i  software fetch enable, honoured only in RUN
//   pwr_ack_i               power-switch acknowledge (asynchronous)
//   pwr_req_o               power-switch enable
//   iso_o                   isolation enable (1 = isolated)
//   clk_en_o                cluster clock-gate enable
//   cluster_rstn_o          cluster reset, active-low
//   fetch_enable_o          cluster fetch enable
//   pwr_ok_o                1 only in RUN
//   state_o                 current state encoding
//   timeout_err_o           sticky ack-timeout flag, cleared on the next power-up request
module cluster_pwr_seq #(
  parameter int ISO_DELAY   = 4,
  parameter int RST_DELAY   = 8,
  parameter int ACK_TIMEOUT = 1024,
  parameter int CNT_WIDTH   = 16
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       cluster_pow_i,
  input  logic       cluster_byp_i,
  input  logic       cluster_rstn_i,
  input  logic       cluster_fetch_enable_i,
  input  logic       pwr_ack_i,
  output logic       pwr_req_o,
  output logic       iso_o,
  output logic       clk_en_o,
  output logic       cluster_rstn_o,
  output logic       fetch_enable_o,
  output logic       pwr_ok_o,
  output logic [3:0] state_o,
  output logic       timeout_err_o
);

  typedef enum logic [3:0] {
    ST_OFF        = 4'd0,
    ST_PWR_UP     = 4'd1,
    ST_ISO_REL    = 4'd2,
    ST_CLK_ON     = 4'd3,
    ST_RUN        = 4'd4,
    ST_RST_ASSERT = 4'd5,
    ST_CLK_OFF    = 4'd6,
    ST_ISO_ON     = 4'd7,
    ST_PWR_DN     = 4'd8
  } state_t;

  // Terminal counter values: a state lasting D cycles exits when the counter reads D-1.
  localparam logic [CNT_WIDTH-1:0] ISO_LAST = CNT_WIDTH'(ISO_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] RST_LAST = CNT_WIDTH'(RST_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] ACK_LAST = CNT_WIDTH'(ACK_TIMEOUT - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_ack_meta;
  logic                 r_ack_s;
  logic                 r_pwr_req;
  logic                 r_iso;
  logic                 r_clk_en;
  logic                 r_rstn;
  logic                 r_fetch;
  logic                 r_pwr_ok;
  logic                 r_terr;

  logic w_req;
  logic w_terr_nxt;
  logic w_pwr_req_nxt;
  logic w_iso_nxt;
  logic w_clk_en_nxt;
  logic w_rstn_nxt;
  logic w_fetch_nxt;
  logic w_run_hold;

  assign w_req = cluster_pow_i & ~cluster_byp_i;

  // Next-state logic. req is only looked at in OFF and RUN, so both sequences run to completion.
  always_comb begin
    w_state_nxt = r_state;
    w_terr_nxt  = r_terr;
    case (r_state)
      ST_OFF: begin
        if (w_req) begin
          w_state_nxt = ST_PWR_UP;
          w_terr_nxt  = 1'b0;
        end
      end
      ST_PWR_UP: begin
        // Ack wins over a timeout landing on the same cycle.
        if (r_ack_s) begin
          w_state_nxt = ST_ISO_REL;
        end else if (r_cnt == ACK_LAST) begin
          w_state_nxt = ST_PWR_DN;
          w_terr_nxt  = 1'b1;
        end
      end
      ST_ISO_REL: begin
        if (r_cnt == ISO_LAST) w_state_nxt = ST_CLK_ON;
      end
      ST_CLK_ON: begin
        if (r_cnt == RST_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!w_req) w_state_nxt = ST_RST_ASSERT;
      end
      ST_RST_ASSERT: begin
        if (r_cnt == RST_LAST) w_state_nxt = ST_CLK_OFF;
      end
      ST_CLK_OFF: begin
        w_state_nxt = ST_ISO_ON;
      end
      ST_ISO_ON: begin
        if (r_cnt == ISO_LAST) w_state_nxt = ST_PWR_DN;
      end
      ST_PWR_DN: begin
        if (!r_ack_s) begin
          w_state_nxt = ST_OFF;
        end else if (r_cnt == ACK_LAST) begin
          w_state_nxt = ST_OFF;
          w_terr_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
      end
    endcase
  end

  // Counter restarts on every state change; OFF/RUN let it free-run since they never compare it.
  assign w_cnt_nxt = (w_state_nxt != r_state) ? '0 : r_cnt + CNT_WIDTH'(1);

  // Output decode from the next state so outputs move on the same edge as the state register.
  always_comb begin
    w_pwr_req_nxt = 1'b0;
    w_iso_nxt     = 1'b1;
    w_clk_en_nxt  = 1'b0;
    case (w_state_nxt)
      ST_PWR_UP, ST_ISO_REL, ST_ISO_ON: begin
        w_pwr_req_nxt = 1'b1;
      end
      ST_CLK_ON, ST_RUN, ST_RST_ASSERT: begin
        w_pwr_req_nxt = 1'b1;
        w_iso_nxt     = 1'b0;
        w_clk_en_nxt  = 1'b1;
      end
      ST_CLK_OFF: begin
        w_pwr_req_nxt = 1'b1;
        w_iso_nxt     = 1'b0;
      end
      default: begin
        w_pwr_req_nxt = 1'b0;
      end
    endcase
  end

  // Software reset/fetch are only passed through once RUN has been held for a cycle, so the
  // cluster always comes out of reset one cycle after RUN entry and drops it on RUN exit.
  assign w_run_hold  = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
  assign w_rstn_nxt  = w_run_hold & cluster_rstn_i;
  assign w_fetch_nxt = w_run_hold & cluster_rstn_i & cluster_fetch_enable_i;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
    end else begin
      r_ack_meta <= pwr_ack_i;
      r_ack_s    <= r_ack_meta;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state   <= ST_OFF;
      r_cnt     <= '0;
      r_pwr_req <= 1'b0;
      r_iso     <= 1'b1;
      r_clk_en  <= 1'b0;
      r_rstn    <= 1'b0;
      r_fetch   <= 1'b0;
      r_pwr_ok  <= 1'b0;
      r_terr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pwr_req <= w_pwr_req_nxt;
      r_iso     <= w_iso_nxt;
      r_clk_en  <= w_clk_en_nxt;
      r_rstn    <= w_rstn_nxt;
      r_fetch   <= w_fetch_nxt;
      r_pwr_ok  <= (w_state_nxt == ST_RUN);
      r_terr    <= w_terr_nxt;
    end
  end

  assign pwr_req_o      = r_pwr_req;
  assign iso_o          = r_iso;
  assign clk_en_o       = r_clk_en;
  assign cluster_rstn_o = r_rstn;
  assign fetch_enable_o = r_fetch;
  assign pwr_ok_o       = r_pwr_ok;
  assign state_o        = r_state;
  assign timeout_err_o  = r_terr;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Testbench for cluster_pwr_seq: scoreboard of expected state entries (state, dwell of the
// previous state, output vector at entry) plus direct checks of reset and RUN-time controls.
module tb_cluster_pwr_seq;

  logic       HCLK;
  logic       HRESET;
  logic       cluster_pow_i;
  logic       cluster_byp_i;
  logic       cluster_rstn_i;
  logic       cluster_fetch_enable_i;
  logic       pwr_ack_i;
  logic       pwr_req_o;
  logic       iso_o;
  logic       clk_en_o;
  logic       cluster_rstn_o;
  logic       fetch_enable_o;
  logic       pwr_ok_o;
  logic [3:0] state_o;
  logic       timeout_err_o;

  logic ack_kill;
  logic ack_d1;

  int n_checks;
  int n_fail;

  typedef struct {
    int         st;
    int         dwell;   // -1: previous state's duration not checked
    logic [6:0] outv;    // {pwr_req, iso, clk_en, rstn, fetch, pwr_ok, terr} at entry
  } exp_t;

  exp_t sb[$];

  cluster_pwr_seq #(
    .ISO_DELAY  (4),
    .RST_DELAY  (8),
    .ACK_TIMEOUT(16),
    .CNT_WIDTH  (16)
  ) dut (
    .HCLK                  (HCLK),
    .HRESET                (HRESET),
    .cluster_pow_i         (cluster_pow_i),
    .cluster_byp_i         (cluster_byp_i),
    .cluster_rstn_i        (cluster_rstn_i),
    .cluster_fetch_enable_i(cluster_fetch_enable_i),
    .pwr_ack_i             (pwr_ack_i),
    .pwr_req_o             (pwr_req_o),
    .iso_o                 (iso_o),
    .clk_en_o              (clk_en_o),
    .cluster_rstn_o        (cluster_rstn_o),
    .fetch_enable_o        (fetch_enable_o),
    .pwr_ok_o              (pwr_ok_o),
    .state_o               (state_o),
    .timeout_err_o         (timeout_err_o)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // Power-switch model: ack follows pwr_req_o, becoming visible in the third cycle after the
  // request edge; ack_kill models a switch that never answers.
  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ack_d1    <= 1'b0;
      pwr_ack_i <= 1'b0;
    end else begin
      ack_d1    <= pwr_req_o;
      pwr_ack_i <= ack_d1 & ~ack_kill;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_outs(input int st, input logic terr);
    logic [2:0] p;
    case (st)
      0, 8:    p = 3'b010;
      1, 2, 7: p = 3'b110;
      3, 4, 5: p = 3'b101;
      6:       p = 3'b100;
      default: p = 3'b000;
    endcase
    return {p, 2'b00, logic'(st == 4), terr};
  endfunction

  task automatic push(input int st, input int dwell, input logic terr);
    exp_t e;
    e.st    = st;
    e.dwell = dwell;
    e.outv  = exp_outs(st, terr);
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #2;
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      step(1);
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic wait_state(input int st, input string tag);
    for (int i = 0; i < 300; i++) begin
      if (int'(state_o) == st) break;
      step(1);
    end
    chk(tag, state_o, st);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_outs"}, {pwr_req_o, iso_o, clk_en_o, cluster_rstn_o, fetch_enable_o, pwr_ok_o, timeout_err_o},
        7'b0100000);
  endtask

  // Monitor: on each state change pop the next expectation and compare.
  initial begin
    int   prev_st;
    int   dwell;
    exp_t e;
    prev_st = 0;
    dwell   = 0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        prev_st = 0;
        dwell   = 0;
      end else begin
        if (int'(state_o) != prev_st) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected", state_o, prev_st);
          end else begin
            e = sb.pop_front();
            chk("sb_state", state_o, e.st);
            if (e.dwell >= 0) chk("sb_dwell", dwell, e.dwell);
            chk("sb_outs", {pwr_req_o, iso_o, clk_en_o, cluster_rstn_o, fetch_enable_o, pwr_ok_o, timeout_err_o},
                e.outv);
          end
          prev_st = int'(state_o);
          dwell   = 1;
        end else begin
          dwell++;
        end
        // Powered, clock stopped and isolation released is only legal in CLK_OFF.
        chk("iso_guard", 32'(pwr_req_o & ~clk_en_o & ~iso_o & (state_o != 4'd6)), 0);
      end
    end
  end

  initial begin
    n_checks               = 0;
    n_fail                 = 0;
    HRESET                 = 1'b1;
    cluster_pow_i          = 1'b0;
    cluster_byp_i          = 1'b0;
    cluster_rstn_i         = 1'b1;
    cluster_fetch_enable_i = 1'b1;
    ack_kill               = 1'b0;
    step(3);
    chk_reset_vals("reset");

    // Bypass holds the cluster off even with pow=1.
    cluster_pow_i = 1'b1;
    cluster_byp_i = 1'b1;
    step(1);
    HRESET = 1'b0;
    step(10);
    chk("byp_state", state_o, 0);
    chk("byp_pwr_req", pwr_req_o, 0);

    // Power-up.
    push(1, -1, 1'b0);
    push(2, 5, 1'b0);
    push(3, 4, 1'b0);
    push(4, 8, 1'b0);
    cluster_byp_i = 1'b0;
    wait_drain("pu_drain");
    chk("run_rstn", cluster_rstn_o, 1);
    chk("run_fetch", fetch_enable_o, 1);
    chk("run_ok", pwr_ok_o, 1);

    // Runtime reset control in RUN.
    cluster_rstn_i = 1'b0;
    #1;
    chk("rstn_latency", cluster_rstn_o, 1);
    step(1);
    chk("rstn_low", cluster_rstn_o, 0);
    chk("fetch_gated", fetch_enable_o, 0);
    cluster_rstn_i = 1'b1;
    step(1);
    chk("rstn_high", cluster_rstn_o, 1);
    chk("fetch_back", fetch_enable_o, 1);
    cluster_fetch_enable_i = 1'b0;
    step(1);
    chk("fetch_off", fetch_enable_o, 0);
    chk("rstn_kept", cluster_rstn_o, 1);
    cluster_fetch_enable_i = 1'b1;
    step(1);
    chk("run_stays", state_o, 4);

    // Power-down.
    push(5, -1, 1'b0);
    push(6, 8, 1'b0);
    push(7, 1, 1'b0);
    push(8, 4, 1'b0);
    push(0, 5, 1'b0);
    cluster_pow_i = 1'b0;
    wait_drain("pd_drain");

    // Ack timeout on power-up.
    ack_kill = 1'b1;
    push(1, -1, 1'b0);
    push(8, 16, 1'b1);
    push(0, 1, 1'b1);
    cluster_pow_i = 1'b1;
    wait_state(8, "to_reach_dn");
    cluster_pow_i = 1'b0;
    wait_drain("to_drain");
    step(4);
    chk("to_sticky", timeout_err_o, 1);
    chk("to_off", state_o, 0);
    ack_kill = 1'b0;
    step(2);

    // Second request clears the error; drop pow mid power-up (abort ignored until RUN).
    push(1, -1, 1'b0);
    push(2, 5, 1'b0);
    push(3, 4, 1'b0);
    push(4, 8, 1'b0);
    push(5, 1, 1'b0);
    push(6, 8, 1'b0);
    push(7, 1, 1'b0);
    push(8, 4, 1'b0);
    push(0, 5, 1'b0);
    cluster_pow_i = 1'b1;
    wait_state(2, "ab_reach_iso");
    cluster_pow_i = 1'b0;
    wait_drain("ab_drain");

    // Reset asserted mid-sequence takes effect without a clock edge.
    push(1, -1, 1'b0);
    push(2, 5, 1'b0);
    push(3, 4, 1'b0);
    cluster_pow_i = 1'b1;
    wait_drain("mr_drain");
    chk("mr_pre_state", state_o, 3);
    HRESET = 1'b1;
    #1;
    chk_reset_vals("mid_reset");
    step(3);
    push(1, -1, 1'b0);
    push(2, 5, 1'b0);
    push(3, 4, 1'b0);
    push(4, 8, 1'b0);
    HRESET = 1'b0;
    #1;
    chk("post_rst_state", state_o, 0);
    wait_drain("restart_drain");

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cluster_pwr_seq.md
Name: cluster_pwr_seq

Overview:
Cluster power/boot sequencer placed directly downstream of the SoC control register block. It takes the software-written cluster power, bypass, reset and fetch-enable bits and converts them into a glitch-free, ordered sequence of outputs toward the cluster power switch, isolation cells, clock gate and core reset. Each step waits on a power-switch acknowledge or a fixed settling delay. It also reports a status code and a sticky acknowledge-timeout error for readback.

Parameters:
ISO_DELAY, 4, cycles spent in ISO_REL and ISO_ON; must be >= 1
RST_DELAY, 8, cycles spent in CLK_ON and RST_ASSERT; must be >= 1
ACK_TIMEOUT, 1024, maximum cycles spent waiting for the synchronized ack in PWR_UP or PWR_DN; must be >= 1
CNT_WIDTH, 16, counter width; must satisfy 2^CNT_WIDTH > max(ISO_DELAY, RST_DELAY, ACK_TIMEOUT)

Ports:
HCLK  in  1  system clock
HRESET  in  1  asynchronous reset, active-high
cluster_pow_i  in  1  power request from SoC control
cluster_byp_i  in  1  cluster bypass; 1 forces power-down
cluster_rstn_i  in  1  software cluster reset, active-low
cluster_fetch_enable_i  in  1  software fetch enable
pwr_ack_i  in  1  power-switch acknowledge, asynchronous
pwr_req_o  out  1  power-switch enable
iso_o  out  1  isolation enable (1 = isolated)
clk_en_o  out  1  cluster clock-gate enable
cluster_rstn_o  out  1  cluster reset, active-low
fetch_enable_o  out  1  cluster fetch enable
pwr_ok_o  out  1  1 only in RUN
state_o  out  4  current state encoding
timeout_err_o  out  1  sticky acknowledge-timeout flag

Behaviour:
- Power request: req = cluster_pow_i & ~cluster_byp_i.
- pwr_ack_i passes through a 2-flop synchronizer; ack_s is the synchronizer output.
- All outputs are flops, updated in the same edge as the state register. No combinational paths from inputs to outputs.
- Reset values: state OFF, pwr_req_o 0, iso_o 1, clk_en_o 0, cluster_rstn_o 0, fetch_enable_o 0, pwr_ok_o 0, timeout_err_o 0, synchronizer 0, counter 0.
- State encodings: OFF=0, PWR_UP=1, ISO_REL=2, CLK_ON=3, RUN=4, RST_ASSERT=5, CLK_OFF=6, ISO_ON=7, PWR_DN=8.
- Output values per state, in the order pwr_req / iso / clk_en / rstn / fetch:
  - OFF: 0/1/0/0/0
  - PWR_UP: 1/1/0/0/0
  - ISO_REL: 1/1/0/0/0
  - CLK_ON: 1/0/1/0/0
  - RUN: 1/0/1/R/F, where R = cluster_rstn_i and F = cluster_fetch_enable_i & cluster_rstn_i, both registered with 1-cycle latency
  - RST_ASSERT: 1/0/1/0/0
  - CLK_OFF: 1/0/0/0/0
  - ISO_ON: 1/1/0/0/0
  - PWR_DN: 0/1/0/0/0
- Counter: cleared on every state change and increments each cycle while the state is unchanged. A delay state of D cycles exits when counter == D-1.
- Transitions:
  - OFF -> PWR_UP when req=1. timeout_err_o is cleared on this transition.
  - PWR_UP -> ISO_REL when ack_s=1.
  - PWR_UP -> PWR_DN when counter == ACK_TIMEOUT-1 and ack_s=0; timeout_err_o is set. Ack takes priority if both occur in the same cycle.
  - ISO_REL -> CLK_ON after ISO_DELAY cycles.
  - CLK_ON -> RUN after RST_DELAY cycles.
  - RUN -> RST_ASSERT when req=0.
  - RST_ASSERT -> CLK_OFF after RST_DELAY cycles.
  - CLK_OFF -> ISO_ON after 1 cycle.
  - ISO_ON -> PWR_DN after ISO_DELAY cycles.
  - PWR_DN -> OFF when ack_s=0.
  - PWR_DN -> OFF when counter == ACK_TIMEOUT-1 and ack_s=1; timeout_err_o is set.
- req is sampled only in OFF and RUN. The power-up and power-down sequences are non-abortable:
  - req dropping mid power-up: sequencer completes to RUN, then leaves RUN on the next cycle.
  - req rising mid power-down: sequencer completes to OFF, then re-enters PWR_UP on the next cycle.
- cluster_byp_i=1 while in RUN starts the power-down sequence, identical to cluster_pow_i=0.
- HRESET asserted in any state forces reset values asynchronously. pwr_req_o drops immediately and iso_o rises immediately. Downstream must tolerate abrupt power removal on reset.
- Glitch-free requirement: no output may toggle more than once per state transition. In the RUN-state delay-free path, iso_o never reads 0 while clk_en_o=0 and pwr_req_o=1, except in CLK_OFF (1 cycle, by design).

Test Plan:
- Common settings: ISO_DELAY=4, RST_DELAY=8, ACK_TIMEOUT=16; pwr_ack_i tied to pwr_req_o with 3 cycles of delay.
1. Power-up: pow=1, byp=0, rstn_i=1, fetch_i=1 -> pwr_req_o rises 1 cycle later. ISO_REL is entered 5 cycles after PWR_UP (3 cycles ack delay + 2 cycles sync). iso_o falls 4 cycles later. RUN is entered 8 cycles after CLK_ON. rstn_o=1 and fetch_o=1 on the cycle after RUN entry. state_o sequence is 0,1,2,3,4.
2. Power-down: pow=0 in RUN -> rstn_o=0, fetch_o=0 next cycle. clk_en_o falls 8 cycles later. iso_o rises 1 cycle after that. pwr_req_o falls 4 cycles later. OFF is reached when ack_s=0. iso_o stays 1 throughout.
3. Ack timeout: pwr_ack_i held 0, pow=1 -> 16 cycles in PWR_UP, then PWR_DN with timeout_err_o=1, then OFF (ack_s=0). A second request clears timeout_err_o on entering PWR_UP.
4. Bypass and abort: byp=1 with pow=1 from reset -> state stays OFF. Dropping pow during ISO_REL -> sequence still reaches RUN, and RST_ASSERT is entered on the very next cycle.
5. Runtime reset control: in RUN toggle rstn_i 1->0->1 with fetch_i=1 -> rstn_o and fetch_o follow with 1-cycle latency; state remains RUN.
6. Reset mid-sequence: assert HRESET during CLK_ON -> all outputs show reset values without waiting for a clock edge. After release, state_o=0 and pow=1 restarts from PWR_UP.
